// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcode map, instruction format and decoded record.
package riscv_pkg;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_AMO    = 7'b0101111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R       = 3'd0,
        FMT_I       = 3'd1,
        FMT_S       = 3'd2,
        FMT_B       = 3'd3,
        FMT_U       = 3'd4,
        FMT_J       = 3'd5,
        FMT_ILLEGAL = 3'd6
    } fmt_e;

    // Width-independent part of a decoded beat; pc and imm travel alongside it.
    typedef struct packed {
        fmt_e       fmt;
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] func3;
        logic [6:0] func7;
        logic       illegal;
    } decoded_t;

    // Every legal opcode ends in 2'b11, so unlisted encodings also catch bad low bits.
    function automatic fmt_e opcode_fmt(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_OP, OP_AMO:                                   f = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE:   f = FMT_I;
            OP_STORE:                                        f = FMT_S;
            OP_BRANCH:                                       f = FMT_B;
            OP_LUI, OP_AUIPC:                                f = FMT_U;
            OP_JAL:                                          f = FMT_J;
            default:                                         f = FMT_ILLEGAL;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate builder: assembles the per-format immediate and sign-extends it to XLEN.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:7]     instr,
    input  fmt_e            fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage.sv
// Registered decode stage: decodes the incoming beat, holds it in an output register with a
// one-entry skid behind it so a stalled execute stage never costs a bubble or drops a beat.
module id_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [2:0]          out_fmt,
    output logic [6:0]          out_opcode,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [2:0]          out_func3,
    output logic [6:0]          out_func7,
    output logic [XLEN-1:0]     out_imm,
    output logic                out_illegal
);

    decoded_t            dec;
    logic [XLEN-1:0]     dec_imm;

    decoded_t            out_q;
    logic [PC_WIDTH-1:0] out_pc_q;
    logic [XLEN-1:0]     out_imm_q;
    logic                out_valid_q;

    decoded_t            skid_q;
    logic [PC_WIDTH-1:0] skid_pc_q;
    logic [XLEN-1:0]     skid_imm_q;
    logic                skid_valid_q;

    logic                accept;
    logic                out_free;

    // Field extraction: fields absent from the format stay zero.
    always_comb begin
        dec         = '0;
        dec.opcode  = in_instr[6:0];
        dec.fmt     = opcode_fmt(in_instr[6:0]);
        dec.illegal = (dec.fmt == FMT_ILLEGAL);
        case (dec.fmt)
            FMT_R: begin
                dec.rd    = in_instr[11:7];
                dec.rs1   = in_instr[19:15];
                dec.rs2   = in_instr[24:20];
                dec.func3 = in_instr[14:12];
                dec.func7 = in_instr[31:25];
            end
            FMT_I: begin
                dec.rd    = in_instr[11:7];
                dec.rs1   = in_instr[19:15];
                dec.func3 = in_instr[14:12];
            end
            FMT_S, FMT_B: begin
                dec.rs1   = in_instr[19:15];
                dec.rs2   = in_instr[24:20];
                dec.func3 = in_instr[14:12];
            end
            FMT_U, FMT_J: begin
                dec.rd    = in_instr[11:7];
            end
            default: ;
        endcase
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr[31:7]),
        .fmt   (dec.fmt),
        .imm   (dec_imm)
    );

    assign in_ready = !rst && !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid_q || out_ready;

    // Output register refills from skid first, so beat order is preserved.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            out_pc_q     <= '0;
            out_imm_q    <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_pc_q    <= '0;
            skid_imm_q   <= '0;
            skid_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_pc_q     <= skid_pc_q;
                out_imm_q    <= skid_imm_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                out_q       <= dec;
                out_pc_q    <= in_pc;
                out_imm_q   <= dec_imm;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q       <= dec;
            skid_pc_q    <= in_pc;
            skid_imm_q   <= dec_imm;
            skid_valid_q <= 1'b1;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_fmt     = out_q.fmt;
    assign out_opcode  = out_q.opcode;
    assign out_rd      = out_q.rd;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_func3   = out_q.func3;
    assign out_func7   = out_q.func7;
    assign out_imm     = out_imm_q;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode vectors, skid/backpressure streaming and flush.
module tb_id_stage;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [2:0]  out_fmt;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_func3;
    logic [6:0]  out_func7;
    logic [31:0] out_imm;
    logic        out_illegal;

    logic        w_in_ready, w_out_valid, w_out_illegal;
    logic [31:0] w_out_pc;
    logic [2:0]  w_out_fmt, w_out_func3;
    logic [6:0]  w_out_opcode, w_out_func7;
    logic [4:0]  w_out_rd, w_out_rs1, w_out_rs2;
    logic [63:0] w_out_imm;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [31:0] got_pc[$];
    int          got_cyc[$];

    id_stage #(.XLEN(32), .PC_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_fmt(out_fmt),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_func3(out_func3), .out_func7(out_func7), .out_imm(out_imm),
        .out_illegal(out_illegal)
    );

    id_stage #(.XLEN(64), .PC_WIDTH(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_pc(w_out_pc), .out_fmt(w_out_fmt),
        .out_opcode(w_out_opcode), .out_rd(w_out_rd), .out_rs1(w_out_rs1), .out_rs2(w_out_rs2),
        .out_func3(w_out_func3), .out_func7(w_out_func7), .out_imm(w_out_imm),
        .out_illegal(w_out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output transfer, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_pc.push_back(out_pc);
            got_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        check("send_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic check_fields(input string tag, input logic [2:0] fmt, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm, input logic ill, input logic [31:0] pc);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_fmt"}, out_fmt, fmt);
        check({tag, "_rd"}, out_rd, rd);
        check({tag, "_rs1"}, out_rs1, rs1);
        check({tag, "_rs2"}, out_rs2, rs2);
        check({tag, "_func3"}, out_func3, f3);
        check({tag, "_func7"}, out_func7, f7);
        check({tag, "_imm"}, out_imm, imm);
        check({tag, "_illegal"}, out_illegal, ill);
        check({tag, "_pc"}, out_pc, pc);
    endtask

    // Streams n beats; out_ready is low for loop cycles stall_lo..stall_hi.
    task automatic run_stream(input string tag, input logic [31:0] base, input int n,
                              input int stall_lo, input int stall_hi);
        int  idx = 0;
        int  c = 0;
        bit  took;
        bit  saw_full = 0;
        got_pc.delete();
        got_cyc.delete();
        while (got_pc.size() < n && c < 40) begin
            in_valid  = (idx < n);
            in_instr  = 32'h00100093;
            in_pc     = base + 32'(4 * idx);
            out_ready = !(c >= stall_lo && c <= stall_hi);
            @(negedge clk);
            took = in_valid && in_ready;
            if (!in_ready) saw_full = 1;
            if (c == stall_hi && stall_lo <= stall_hi)
                check({tag, "_hold_pc"}, out_pc, base);
            @(posedge clk); #1;
            if (took) idx++;
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_count"}, got_pc.size(), n);
        for (int i = 0; i < got_pc.size(); i++)
            check({tag, "_order"}, got_pc[i], base + 32'(4 * i));
        if (got_cyc.size() >= 2)
            check({tag, "_b2b"}, got_cyc[got_cyc.size()-1] - got_cyc[0], n - 1);
        check({tag, "_saw_full"}, saw_full, stall_lo <= stall_hi);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00000013;
        in_pc     = 32'h0000_0000;
        out_ready = 1'b1;

        repeat (3) begin
            @(posedge clk); #1;
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 0);
        end
        check("rst_out_pc", out_pc, 0);
        check("rst_out_imm", out_imm, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        // addi x1,x2,-1
        send(32'hFFF10093, 32'h1000);
        check_fields("addi", FMT_I, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b0, 32'h1000);
        // beq x0,x0,-4
        send(32'hFE000EE3, 32'h1004);
        check_fields("beq", FMT_B, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b0, 32'h1004);
        // sw x5,-4(x2)
        send(32'hFE512E23, 32'h1008);
        check_fields("sw", FMT_S, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'hFFFFFFFC, 1'b0, 32'h1008);
        // jal x1,-8
        send(32'hFF9FF0EF, 32'h100C);
        check_fields("jal", FMT_J, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFF8, 1'b0, 32'h100C);
        // sub x3,x1,x2
        send(32'h402081B3, 32'h1010);
        check_fields("sub", FMT_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0, 1'b0, 32'h1010);
        // unlisted opcode
        send(32'h0000007F, 32'h1014);
        check_fields("ill7f", FMT_ILLEGAL, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 1'b1, 32'h1014);
        check("ill7f_opcode", out_opcode, 7'h7F);
        // low bits not 2'b11
        send(32'hFFF10090, 32'h1018);
        check_fields("ill_lo", FMT_ILLEGAL, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 1'b1, 32'h1018);
        // lui x3,0x80000 on both widths
        send(32'h800001B7, 32'h101C);
        check_fields("lui", FMT_U, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h80000000, 1'b0, 32'h101C);
        check("lui64_imm", w_out_imm, 64'hFFFFFFFF80000000);
        check("lui64_rd", w_out_rd, 5'd3);
        @(posedge clk); #1;
        check("drain_out_valid", out_valid, 0);

        run_stream("stall", 32'h0100, 4, 1, 3);
        run_stream("free", 32'h0300, 4, 1, 0);

        // fill output register and skid, then flush with a beat offered
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(32'h00100093, 32'h0200);
        send(32'h00200113, 32'h0204);
        check("fill_in_ready", in_ready, 0);
        check("fill_out_valid", out_valid, 1);
        got_pc.delete();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00300193;
        in_pc    = 32'h0208;
        @(posedge clk); #1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("flush_no_emit", got_pc.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
